// File: rtl/ofs_plat_axi_mem_lite_csr_responder.sv
// AXI-lite responder terminating in a bank of N_REGS CSRs, with per-register write pulses to local logic.
// Define OFS_PLAT_AXI_MEM_LITE_CSR_ID_REG_EN to make CSR 0 a read-only ID register returning ID_VALUE.
module ofs_plat_axi_mem_lite_csr_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int N_REGS = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [63:0] ID_VALUE = 64'h0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [ADDR_WIDTH-1:0]        awaddr,
    input  logic [2:0]                   awprot,
    input  logic                         wvalid,
    output logic                         wready,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    output logic                         bvalid,
    input  logic                         bready,
    output logic [1:0]                   bresp,
    input  logic                         arvalid,
    output logic                         arready,
    input  logic [ADDR_WIDTH-1:0]        araddr,
    input  logic [2:0]                   arprot,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic [1:0]                   rresp,
    output logic [N_REGS*DATA_WIDTH-1:0] csr_q,
    output logic [N_REGS-1:0]            csr_wr_pulse
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] N_REGS_IDX = ADDR_WIDTH'(N_REGS);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic [DATA_WIDTH-1:0] csr [N_REGS];

    logic [ADDR_WIDTH-1:0] ar_idx;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  ar_fire;
    logic                  wr_commit;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_ok;

    assign awready   = reset_n && !aw_held;
    assign wready    = reset_n && !w_held;
    assign arready   = reset_n && !rvalid;
    assign aw_fire   = awvalid && awready;
    assign w_fire    = wvalid && wready;
    assign ar_fire   = arvalid && arready;
    // A commit stalls while a previous B response is still waiting for bready.
    assign wr_commit = aw_held && w_held && !bvalid;
    assign ar_idx    = araddr >> OFF_BITS;
    assign rd_ok     = ar_idx < N_REGS_IDX;
    assign unused_ok = ^{awprot, arprot, ID_VALUE};

`ifdef OFS_PLAT_AXI_MEM_LITE_CSR_ID_REG_EN
    assign wr_ok = (aw_idx_q < N_REGS_IDX) && (aw_idx_q != '0);
`else
    assign wr_ok = aw_idx_q < N_REGS_IDX;
`endif

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (ar_idx == ADDR_WIDTH'(i)) rd_word = csr[i];
        end
`ifdef OFS_PLAT_AXI_MEM_LITE_CSR_ID_REG_EN
        if (ar_idx == '0) rd_word = ID_VALUE[DATA_WIDTH-1:0];
`endif
    end

    always_comb begin
        csr_q = '0;
        for (int i = 0; i < N_REGS; i++) begin
            csr_q[i*DATA_WIDTH +: DATA_WIDTH] = csr[i];
        end
`ifdef OFS_PLAT_AXI_MEM_LITE_CSR_ID_REG_EN
        csr_q[DATA_WIDTH-1:0] = ID_VALUE[DATA_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx_q     <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            bvalid       <= 1'b0;
            bresp        <= '0;
            csr_wr_pulse <= '0;
            for (int i = 0; i < N_REGS; i++) csr[i] <= RESET_VALUE;
        end else begin
            csr_wr_pulse <= '0;
            if (bvalid && bready) bvalid <= 1'b0;
            if (aw_fire) begin
                aw_held  <= 1'b1;
                aw_idx_q <= awaddr >> OFF_BITS;
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (wr_commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < N_REGS; i++) begin
                    if (wr_ok && aw_idx_q == ADDR_WIDTH'(i)) begin
                        csr_wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < STRB_WIDTH; b++) begin
                            if (w_strb_q[b]) csr[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= '0;
        end else begin
            if (rvalid && rready) rvalid <= 1'b0;
            if (ar_fire) begin
                rvalid <= 1'b1;
                rdata  <= rd_ok ? rd_word : '0;
                rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end
endmodule

// File: tb/tb_ofs_plat_axi_mem_lite_csr_responder.sv
// Randomized self-checking bench for ofs_plat_axi_mem_lite_csr_responder against a behavioural CSR model.
// Honours OFS_PLAT_AXI_MEM_LITE_CSR_ID_REG_EN when the bench is built with it.
module tb_ofs_plat_axi_mem_lite_csr_responder;
    localparam int N_REGS = 16;
    localparam logic [63:0] RESET_VALUE = 64'h0;
    localparam logic [63:0] ID_VALUE = 64'hABCD;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic awvalid = 1'b0, awready;
    logic [15:0] awaddr = '0;
    logic [2:0] awprot = '0;
    logic wvalid = 1'b0, wready;
    logic [63:0] wdata = '0;
    logic [7:0] wstrb = '0;
    logic bvalid, bready = 1'b0;
    logic [1:0] bresp;
    logic arvalid = 1'b0, arready;
    logic [15:0] araddr = '0;
    logic [2:0] arprot = '0;
    logic rvalid, rready = 1'b0;
    logic [63:0] rdata;
    logic [1:0] rresp;
    logic [N_REGS*64-1:0] csr_q;
    logic [N_REGS-1:0] csr_wr_pulse;

    int checks = 0;
    int failures = 0;
    logic [63:0] model_csr [N_REGS];

    ofs_plat_axi_mem_lite_csr_responder #(
        .ADDR_WIDTH(16), .DATA_WIDTH(64), .N_REGS(N_REGS),
        .RESET_VALUE(RESET_VALUE), .ID_VALUE(ID_VALUE)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .csr_q(csr_q), .csr_wr_pulse(csr_wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic bit model_writable(input int idx);
        if (idx >= N_REGS) return 1'b0;
`ifdef OFS_PLAT_AXI_MEM_LITE_CSR_ID_REG_EN
        if (idx == 0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [63:0] model_read(input int idx);
        if (idx >= N_REGS) return 64'h0;
`ifdef OFS_PLAT_AXI_MEM_LITE_CSR_ID_REG_EN
        if (idx == 0) return ID_VALUE;
`endif
        return model_csr[idx];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N_REGS; i++) model_csr[i] = RESET_VALUE;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag);
        for (int i = 0; i < N_REGS; i++)
            checkOutput($sformatf("%s_csr%0d", tag, i), csr_q[i*64 +: 64], model_read(i));
    endtask

    // Full write transaction with bready high; AW and W are presented after independent delays.
    task automatic applyStimulus(input logic [15:0] addr, input logic [63:0] data, input logic [7:0] strb,
                                 input int aw_delay, input int w_delay);
        int cyc, idx;
        bit aw_done, w_done, hs_aw, hs_w;
        logic [1:0] exp_resp;
        logic [N_REGS-1:0] exp_pulse;
        idx = int'(addr) / 8;
        cyc = 0; aw_done = 0; w_done = 0;
        awaddr = addr; wdata = data; wstrb = strb; bready = 1'b1;
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid = !aw_done && (cyc >= aw_delay);
            wvalid  = !w_done && (cyc >= w_delay);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            tick();
            aw_done = aw_done | hs_aw;
            w_done  = w_done | hs_w;
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        checkOutput("aw_w_accepted", {aw_done, w_done}, 2'b11);
        checkOutput("b_not_early", bvalid, 1'b0);
        if (model_writable(idx)) begin
            for (int b = 0; b < 8; b++)
                if (strb[b]) model_csr[idx][b*8 +: 8] = data[b*8 +: 8];
            exp_pulse = N_REGS'(1) << idx;
            exp_resp = 2'b00;
        end else begin
            exp_pulse = '0;
            exp_resp = 2'b10;
        end
        tick();
        checkOutput("bvalid", bvalid, 1'b1);
        checkOutput("bresp", bresp, exp_resp);
        checkOutput("wr_pulse", csr_wr_pulse, exp_pulse);
        if (idx < N_REGS) checkOutput("csr_after_wr", csr_q[idx*64 +: 64], model_read(idx));
        tick();
        checkOutput("bvalid_clear", bvalid, 1'b0);
        checkOutput("wr_pulse_clear", csr_wr_pulse, '0);
    endtask

    task automatic readCheck(input logic [15:0] addr, input int stall);
        int idx, cyc;
        bit hs;
        logic [63:0] exp_data;
        logic [1:0] exp_resp;
        idx = int'(addr) / 8;
        exp_data = model_read(idx);
        exp_resp = (idx < N_REGS) ? 2'b00 : 2'b10;
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        hs = 0; cyc = 0;
        while (!hs && cyc < 20) begin
            hs = arready;
            tick();
            cyc++;
        end
        arvalid = 1'b0;
        checkOutput("ar_accepted", hs, 1'b1);
        checkOutput("rvalid", rvalid, 1'b1);
        checkOutput("rdata", rdata, exp_data);
        checkOutput("rresp", rresp, exp_resp);
        for (int s = 0; s < stall; s++) begin
            tick();
            checkOutput("rvalid_hold", rvalid, 1'b1);
            checkOutput("rdata_hold", rdata, exp_data);
            checkOutput("arready_blocked", arready, 1'b0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        checkOutput("rvalid_clear", rvalid, 1'b0);
    endtask

    initial begin
        logic [63:0] d1;
        logic [63:0] old5;
        model_reset();
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_awready", awready, 1'b0);
        checkOutput("rst_wready", wready, 1'b0);
        checkOutput("rst_arready", arready, 1'b0);
        checkOutput("rst_bvalid", bvalid, 1'b0);
        checkOutput("rst_rvalid", rvalid, 1'b0);
        checkOutput("rst_rdata", rdata, 64'h0);
        checkOutput("rst_pulse", csr_wr_pulse, '0);
        checkAll("rst");
        @(negedge clk) reset_n = 1'b1;
        tick();
        checkOutput("awready_up", awready, 1'b1);

        // Directed cases
        applyStimulus(16'h0018, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 0);
        applyStimulus(16'h0008, 64'h11223344_55667788, 8'h0F, 3, 0);
        checkOutput("w_first_csr1", csr_q[1*64 +: 64], 64'h00000000_55667788);
        readCheck(16'h0080, 0);
        applyStimulus(16'h0080, 64'h1234, 8'hFF, 0, 0);
        checkAll("oor");
        applyStimulus(16'h0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1, 0);

        // Read capture on the same edge as a commit to the same CSR
        applyStimulus(16'h0010, 64'h5, 8'hFF, 0, 0);
        awaddr = 16'h0010; wdata = 64'h9; wstrb = 8'hFF; bready = 1'b0;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 16'h0010; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        checkOutput("coll_rvalid", rvalid, 1'b1);
        checkOutput("coll_rdata_old", rdata, 64'h5);
        checkOutput("coll_bvalid", bvalid, 1'b1);
        model_csr[2] = 64'h9;
        for (int s = 0; s < 5; s++) begin
            tick();
            checkOutput("coll_rvalid_hold", rvalid, 1'b1);
            checkOutput("coll_rdata_hold", rdata, 64'h5);
            checkOutput("coll_arready", arready, 1'b0);
        end
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0;
        checkOutput("coll_rvalid_clear", rvalid, 1'b0);
        checkOutput("coll_bvalid_clear", bvalid, 1'b0);
        readCheck(16'h0010, 0);

        // B backpressure with a second AW/W pair queued behind it
        bready = 1'b0;
        awaddr = 16'h0080; wdata = 64'hBAD; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        checkOutput("bp_b1_valid", bvalid, 1'b1);
        checkOutput("bp_b1_resp", bresp, 2'b10);
        d1 = {$urandom, $urandom};
        old5 = model_csr[5];
        awaddr = 16'h0028; wdata = d1; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1;
        checkOutput("bp_awready", awready, 1'b1);
        checkOutput("bp_wready", wready, 1'b1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int s = 0; s < 10; s++) begin
            tick();
            checkOutput("bp_bvalid_hold", bvalid, 1'b1);
            checkOutput("bp_bresp_hold", bresp, 2'b10);
            checkOutput("bp_csr5_wait", csr_q[5*64 +: 64], old5);
            checkOutput("bp_no_pulse", csr_wr_pulse, '0);
            checkOutput("bp_aw_full", awready, 1'b0);
        end
        bready = 1'b1;
        tick();
        checkOutput("bp_b1_done", bvalid, 1'b0);
        tick();
        model_csr[5] = d1;
        checkOutput("bp_b2_valid", bvalid, 1'b1);
        checkOutput("bp_b2_resp", bresp, 2'b00);
        checkOutput("bp_b2_pulse", csr_wr_pulse, N_REGS'(1) << 5);
        checkOutput("bp_csr5", csr_q[5*64 +: 64], d1);
        tick();
        checkOutput("bp_b2_done", bvalid, 1'b0);

`ifdef OFS_PLAT_AXI_MEM_LITE_CSR_ID_REG_EN
        readCheck(16'h0000, 0);
        applyStimulus(16'h0000, 64'h5555, 8'hFF, 0, 0);
        checkOutput("id_unchanged", csr_q[63:0], ID_VALUE);
`endif

        // Randomized mix of reads and writes
        for (int n = 0; n < 60; n++) begin
            logic [15:0] a;
            logic [7:0] s;
            a = 16'(($urandom_range(0, 17) << 3) | $urandom_range(0, 7));
            s = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 2) == 0)
                readCheck(a, int'($urandom_range(0, 2)));
            else
                applyStimulus(a, {$urandom, $urandom}, s,
                              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        checkAll("rand");

        // Reset while a captured write is waiting to commit
        awaddr = 16'h0030; wdata = 64'h7777; wstrb = 8'hFF; bready = 1'b1;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        checkOutput("midrst_bvalid", bvalid, 1'b0);
        checkOutput("midrst_awready", awready, 1'b0);
        checkOutput("midrst_pulse", csr_wr_pulse, '0);
        checkAll("midrst");
        @(negedge clk) reset_n = 1'b1;
        repeat (3) tick();
        checkOutput("postrst_bvalid", bvalid, 1'b0);
        checkOutput("postrst_rvalid", rvalid, 1'b0);
        checkOutput("postrst_csr6", csr_q[6*64 +: 64], model_read(6));
        applyStimulus(16'h0030, 64'h0123_4567_89AB_CDEF, 8'hF0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ofs_plat_axi_mem_lite_csr_responder.md
Name: ofs_plat_axi_mem_lite_csr_responder

Overview:
- AXI-lite sink (responder) terminating an AXI-lite memory interface in a bank of N_REGS read/write CSRs.
- Sits at the far end of a register pipeline, on the AFU side or in the shell.
- Accepts AW/W/AR and produces B/R, with full ready/valid backpressure on every channel.
- Exposes register contents and per-register write strobes to local logic.

Parameters:
ADDR_WIDTH, 16, byte address width on awaddr/araddr
DATA_WIDTH, 64, data width; must be 32 or 64
N_REGS, 16, number of CSRs; 1..256, need not be a power of 2
RESET_VALUE, 0, reset value loaded into every CSR
ID_VALUE, 64'h0, constant returned by register 0 when the optional feature is enabled

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  ADDR_WIDTH  write byte address
awprot  in  3  ignored
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte enables
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  ADDR_WIDTH  read byte address
arprot  in  3  ignored
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
csr_q  out  N_REGS*DATA_WIDTH  current CSR contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
csr_wr_pulse  out  N_REGS  one-cycle pulse per committed write

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on reset_n. All state clears asynchronously on reset_n low.
- Reset values while reset_n is low:
  - awready, wready, arready = 0 (gated by reset_n).
  - bvalid, rvalid = 0; bresp, rresp, rdata = 0.
  - csr_q = RESET_VALUE; csr_wr_pulse = 0.
- Address decode: word index = addr >> log2(DATA_WIDTH/8). Low offset bits are ignored. Index >= N_REGS is out of range.
- Write path: independent one-entry holding registers for AW and W.
  - awready = reset_n && !aw_held; wready = reset_n && !w_held.
  - AW and W may arrive in either order or in the same cycle.
- Write commit: on the first edge where aw_held && w_held && !bvalid.
  - Write wdata bytes selected by wstrb into the indexed CSR.
  - Clear aw_held and w_held, set bvalid, set bresp.
  - Pulse csr_wr_pulse[index] for exactly one cycle, coincident with bvalid rising.
  - Out of range: no CSR change, no pulse, bresp = SLVERR.
- Write latency: AW and W both captured at edge T -> commit at edge T+1. bvalid is high in the cycle after T+1.
- Write overlap: a new AW/W may be captured while bvalid is pending. Its commit waits until bvalid clears. bvalid and bresp hold stable until bready.
- Read path: arready = reset_n && !rvalid.
  - On AR capture at edge T: rdata, rresp and rvalid load at edge T; rvalid is high in cycle T+1.
  - Out of range: rdata = 0, rresp = SLVERR.
  - rvalid, rdata and rresp hold stable until rready.
  - Maximum read throughput is one read per 2 cycles.
- Simultaneous read capture and write commit to the same CSR on the same edge: the read returns the pre-write value.
- wstrb = 0: commit completes with OKAY and csr_wr_pulse fires; data is unchanged.
- Reset mid-transaction: all held requests and pending responses are discarded. No response is issued after reset.

Optional Feature:
- Macro: OFS_PLAT_AXI_MEM_LITE_CSR_ID_REG_EN.
- Defined:
  - CSR 0 is read-only and reads ID_VALUE.
  - Writes to index 0 return SLVERR, leave csr_q[0] = ID_VALUE, and do not pulse.
  - csr_q slice 0 is tied to ID_VALUE.
- Undefined: CSR 0 is an ordinary read/write register.

Test Plan:
- AW(addr 0x18) and W(0xDEADBEEF_CAFEF00D, wstrb 0xFF) in the same cycle, bready=1 -> csr 3 = written value; bvalid 2 cycles after handshake; bresp=00; csr_wr_pulse=16'h0008 for 1 cycle.
- W sent 3 cycles before AW(addr 0x08, wstrb 0x0F, wdata 0x11223344_55667788) on csr reset 0 -> csr 1 = 0x00000000_55667788; single B.
- Read addr 0x80 with N_REGS=16 -> rresp=10, rdata=0. Write to 0x80 -> bresp=10, no csr change, no pulse.
- bready held low 10 cycles while a second AW/W arrives -> second pair accepted; commit delayed until first B handshake; two B responses in order, values stable while stalled.
- Read csr 2 on the same edge as a write commit to csr 2 (old 0x5, new 0x9) -> rdata=0x5; subsequent read -> 0x9. rready low 5 cycles -> rvalid/rdata stable, arready=0.
- With OFS_PLAT_AXI_MEM_LITE_CSR_ID_REG_EN and ID_VALUE=0xABCD: read 0x0 -> 0xABCD OKAY; write 0x0 -> SLVERR, value unchanged. Assert reset_n low mid-write -> bvalid=0, csr_q=RESET_VALUE.
